adc3664_spi_master: RTL and testbench
=====================================

Name: adc3664_spi_master

Overview:
SPI master and command sequencer for the ADC3664 serial configuration port.
- Accepts single register commands (write or read) on a valid/ready interface.
- Serialises each command as one 24-bit SEN-framed transaction: SCLK derived from CLK, tri-state SDIO control.
- Returns read data with a done pulse. Sits between the host/config logic and the ADC3664 SPI slave pins.

Parameters:
CLK_DIV, 4, CLK cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV CLK cycles
LEAD_CYC, 2, CLK cycles from SEN fall to first SCLK low phase (>=1)
TRAIL_CYC, 2, CLK cycles after last SCLK fall before SEN rises (>=1)
GAP_CYC, 4, minimum CLK cycles SEN stays high between frames (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
cmd_rw  in  1  0 = write, 1 = read
cmd_addr  in  12  register address
cmd_wdata  in  8  write data (ignored for reads)
rd_data  out  8  last read result
done  out  1  one-cycle pulse at frame end
busy  out  1  high from acceptance until return to IDLE
err  out  1  one-cycle pulse on rejected command (see Optional Feature)
SCLK  out  1  SPI clock, idles low
SEN  out  1  serial enable, active low
SDIO_out  out  1  serial data to slave
SDIO_oe  out  1  1 = master drives SDIO
SDIO_in  in  1  serial data from slave

Behaviour:
- Clock and reset: one clock CLK; reset Reset_n is asynchronous and active-low.
- Reset values:
  - SEN=1, SCLK=0, SDIO_out=0, SDIO_oe=0.
  - cmd_ready=1 once out of reset.
  - busy=0, done=0, err=0, rd_data=0.
  - FSM in IDLE, all counters 0.
- Reset asserted mid-frame: outputs take reset values immediately; no done pulse; the partial frame is abandoned.
- Frame format, shifted MSB first (bit 23 first): {cmd_rw, 3'b000, cmd_addr[11:0], data[7:0]}. data = cmd_wdata for writes; don't-care for reads, where the master drives nothing.
- Command capture: cmd_rw, cmd_addr and cmd_wdata are latched at acceptance. Input changes after that are ignored.
- FSM states:
  - IDLE: cmd_ready=1. On acceptance go to LEAD, busy=1, SEN=0 from the next cycle.
  - LEAD: LEAD_CYC cycles, SCLK=0. SDIO_oe=1 and SDIO_out=frame bit 23 from the first LEAD cycle.
  - SHIFT: 24 bits, each = low phase (CLK_DIV cycles, SCLK=0) then high phase (CLK_DIV cycles, SCLK=1).
    - SDIO_out changes only at the start of a low phase; it is stable across the SCLK rise, which is when the slave samples.
    - Bit index is a 5-bit down-counter 23..0.
  - SHIFT, read frames:
    - SDIO_oe drops to 0 at the start of the low phase of bit index 7, for the last 8 bits.
    - SDIO_in is sampled on the last CLK cycle of each high phase of bits 7..0 into an 8-bit shift register, MSB first.
  - TRAIL: TRAIL_CYC cycles, SCLK=0, SEN=0, SDIO_oe=0.
  - GAP: SEN=1. On the first GAP cycle: done=1, and for reads rd_data is loaded from the shift register. Lasts GAP_CYC cycles, then IDLE (busy=0, cmd_ready=1).
- Latency: done is high exactly 1+LEAD_CYC+48*CLK_DIV+TRAIL_CYC cycles after the acceptance edge. cmd_ready returns GAP_CYC cycles after done.
  - Defaults: done at +197, cmd_ready at +201.
- Write frames leave rd_data unchanged.
- Back-to-back: cmd_valid held high is accepted on the first IDLE cycle; SEN high time is exactly GAP_CYC+1 cycles.
- SCLK and SEN are registered outputs (glitch-free); SCLK never toggles while SEN=1.

Optional Feature:
Macro ADC_SPI_READ_EN.
- Defined: read frames behave as above.
- Undefined:
  - A command with cmd_rw=1 is still accepted (handshake completes) but produces no frame.
  - err pulses for one cycle on the cycle after acceptance.
  - SEN stays 1, busy=0, no done, rd_data unchanged; cmd_ready stays 1.
  - SDIO_oe is only ever 0 outside write frames.

Test Plan:
- Write addr=0x0A5, data=0x3C, defaults -> SEN low for 196 cycles; slave-model capture = 0x00A53C (bits 23..0); done at +197; rd_data stays 0.
- Read addr=0x123, slave model returns 0xA7, defaults -> first 16 bits on SDIO_out = 0x8123; SDIO_oe=0 for the last 8 bits; rd_data=0xA7 on the done cycle.
- Two writes with cmd_valid held high -> second acceptance exactly GAP_CYC cycles after the first done; SEN high time = 5 cycles; both frames captured correctly.
- Reset_n pulsed low during bit 10 of a write -> SEN=1, SCLK=0, SDIO_oe=0 asynchronously; no done; the next write after reset completes normally.
- CLK_DIV=1, LEAD_CYC=TRAIL_CYC=GAP_CYC=1, write 0xFFF/0xFF -> SCLK period 2 cycles; 24 rising edges; done at +51.
- ADC_SPI_READ_EN undefined, read command -> err pulse one cycle after acceptance; SEN never falls; busy stays 0.

Source files
------------

// File: rtl/adc3664_spi_master.sv
// adc3664_spi_master: command sequencer and SPI master for the ADC3664 configuration port.
// Read frames are built only when ADC_SPI_READ_EN is defined; otherwise read commands are rejected with err.
module adc3664_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int LEAD_CYC  = 2,
  parameter int TRAIL_CYC = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [11:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        SCLK,
  output logic        SEN,
  output logic        SDIO_out,
  output logic        SDIO_oe,
  input  logic        SDIO_in
);

  localparam int MAX_A   = (CLK_DIV > LEAD_CYC) ? CLK_DIV : LEAD_CYC;
  localparam int MAX_B   = (TRAIL_CYC > GAP_CYC) ? TRAIL_CYC : GAP_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LEAD_LD  = CW'(LEAD_CYC - 1);
  localparam logic [CW-1:0] TRAIL_LD = CW'(TRAIL_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [4:0]    bit_idx;
  logic          phase_hi;
  logic          rw_q;
  logic [23:0]   frame_q;
  logic [7:0]    rx_sr;

  logic [23:0]   cmd_frame;
  logic [4:0]    next_idx;
  logic          frame_ok;

  // Read frames carry zeros in the data field; the slave owns SDIO there.
  assign cmd_frame = {cmd_rw, 3'b000, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
  assign next_idx  = bit_idx - 5'd1;

`ifdef ADC_SPI_READ_EN
  assign frame_ok = 1'b1;
`else
  assign frame_ok = ~cmd_rw;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      cyc_cnt   <= '0;
      bit_idx   <= '0;
      phase_hi  <= 1'b0;
      rw_q      <= 1'b0;
      frame_q   <= '0;
      rx_sr     <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
      SCLK      <= 1'b0;
      SEN       <= 1'b1;
      SDIO_out  <= 1'b0;
      SDIO_oe   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; pulse outputs default low and are raised for one cycle below.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (frame_ok) begin
              state     <= S_LEAD;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              SEN       <= 1'b0;
              SDIO_oe   <= 1'b1;
              SDIO_out  <= cmd_frame[23];
              frame_q   <= cmd_frame;
              rw_q      <= cmd_rw;
              cyc_cnt   <= LEAD_LD;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_LEAD: begin
          if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end else begin
            state    <= S_SHIFT;
            bit_idx  <= 5'd23;
            phase_hi <= 1'b0;
            cyc_cnt  <= DIV_LD;
          end
        end

        S_SHIFT: begin
          if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end else begin
            cyc_cnt <= DIV_LD;
            if (!phase_hi) begin
              phase_hi <= 1'b1;
              SCLK     <= 1'b1;
            end else begin
              // End of a high phase: sample read data, then open the next low phase.
              phase_hi <= 1'b0;
              SCLK     <= 1'b0;
              if (rw_q && bit_idx < 5'd8)
                rx_sr <= {rx_sr[6:0], SDIO_in};
              if (bit_idx == 5'd0) begin
                state    <= S_TRAIL;
                cyc_cnt  <= TRAIL_LD;
                SDIO_oe  <= 1'b0;
                SDIO_out <= 1'b0;
              end else begin
                bit_idx  <= next_idx;
                SDIO_out <= frame_q[next_idx];
                if (rw_q && next_idx == 5'd7)
                  SDIO_oe <= 1'b0;
              end
            end
          end
        end

        S_TRAIL: begin
          if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end else begin
            state   <= S_GAP;
            SEN     <= 1'b1;
            done    <= 1'b1;
            cyc_cnt <= GAP_LD;
            if (rw_q)
              rd_data <= rx_sr;
          end
        end

        S_GAP: begin
          if (cyc_cnt != '0) begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc3664_spi_master.sv
// Directed bench for adc3664_spi_master: default-timing instance plus a fastest-timing instance,
// each watched by a small SPI slave model that captures SDIO on SCLK rises.
module tb_adc3664_spi_master;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        cmd_valid = 1'b0;
  logic        cmd_rw    = 1'b0;
  logic [11:0] cmd_addr  = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_ready, done, busy, err, sclk, sen, sdio_out, sdio_oe;
  logic [7:0]  rd_data;
  logic        sdio_in = 1'b0;

  logic        f_valid = 1'b0;
  logic        f_rw    = 1'b0;
  logic [11:0] f_addr  = '0;
  logic [7:0]  f_wdata = '0;
  logic        f_ready, f_done, f_busy, f_err, f_sclk, f_sen, f_out, f_oe;
  logic [7:0]  f_rd;
  logic        f_sdio_in = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc3664_spi_master u_dut (
    .CLK(clk), .Reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_data(rd_data), .done(done), .busy(busy), .err(err),
    .SCLK(sclk), .SEN(sen), .SDIO_out(sdio_out), .SDIO_oe(sdio_oe), .SDIO_in(sdio_in)
  );

  adc3664_spi_master #(.CLK_DIV(1), .LEAD_CYC(1), .TRAIL_CYC(1), .GAP_CYC(1)) u_fast (
    .CLK(clk), .Reset_n(rst_n),
    .cmd_valid(f_valid), .cmd_ready(f_ready), .cmd_rw(f_rw),
    .cmd_addr(f_addr), .cmd_wdata(f_wdata),
    .rd_data(f_rd), .done(f_done), .busy(f_busy), .err(f_err),
    .SCLK(f_sclk), .SEN(f_sen), .SDIO_out(f_out), .SDIO_oe(f_oe), .SDIO_in(f_sdio_in)
  );

  // Slave model for the default instance: clears on SEN fall, shifts on SCLK rise.
  int          rises  = 0;
  logic [23:0] cap    = '0;
  logic [23:0] oe_cap = '0;
  logic [23:0] resp   = '0;

  always @(posedge sclk or negedge sen) begin
    if (sclk) begin
      cap    = {cap[22:0], sdio_out};
      oe_cap = {oe_cap[22:0], sdio_oe};
      rises++;
    end else begin
      cap    = '0;
      oe_cap = '0;
      rises  = 0;
    end
  end

  // The slave drives its response bits from the SCLK fall that opens bits 7..0.
  always @(negedge sclk)
    if (rises >= 16 && rises <= 23) sdio_in = resp[23 - rises];

  int          f_rises = 0;
  logic [23:0] f_cap   = '0;

  always @(posedge f_sclk or negedge f_sen) begin
    if (f_sclk) begin
      f_cap = {f_cap[22:0], f_out};
      f_rises++;
    end else begin
      f_cap   = '0;
      f_rises = 0;
    end
  end

  // Runs one command on the default instance; cycle 0 is the acceptance cycle.
  task automatic do_frame(input logic rw, input logic [11:0] addr, input logic [7:0] wd,
                          output int done_at, output int ready_at, output int sen_low,
                          output int done_cnt, output logic [7:0] rd_at_done);
    bit acc = 1'b0;
    done_at = -1; ready_at = -1; sen_low = 0; done_cnt = 0; rd_at_done = 'x;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~addr; cmd_wdata = ~wd;
      end
      if (!sen) sen_low++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at    = n;
          rd_at_done = rd_data;
        end
      end
      if (cmd_ready) begin
        ready_at = n;
        break;
      end
    end
    cmd_rw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sen, sclk, sdio_oe, sdio_out} !== 4'b1000) begin
      bad++; $display("FAIL reset_pins: got %b want 1000", {sen, sclk, sdio_oe, sdio_out});
    end
    total++;
    if ({busy, done, err} !== 3'b000) begin
      bad++; $display("FAIL reset_status: got %b want 000", {busy, done, err});
    end
    total++;
    if (rd_data !== 8'h00) begin
      bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int d, r, s, dc;
    logic [7:0] rd;
    resp = 24'h0000_5A;
    do_frame(1'b0, 12'h0A5, 8'h3C, d, r, s, dc, rd);
    total++; if (d != 197) begin bad++; $display("FAIL write_done_at: got %0d want 197", d); end
    total++; if (r != 201) begin bad++; $display("FAIL write_ready_at: got %0d want 201", r); end
    total++; if (s != 196) begin bad++; $display("FAIL write_sen_low: got %0d want 196", s); end
    total++; if (dc != 1) begin bad++; $display("FAIL write_done_width: got %0d want 1", dc); end
    total++; if (rises != 24) begin bad++; $display("FAIL write_rises: got %0d want 24", rises); end
    total++;
    if (cap !== 24'h00A53C) begin
      bad++; $display("FAIL write_capture: got %h want 00a53c", cap);
    end
    total++;
    if (oe_cap !== 24'hFFFFFF) begin
      bad++; $display("FAIL write_oe: got %h want ffffff", oe_cap);
    end
    total++;
    if (rd_data !== 8'h00) begin
      bad++; $display("FAIL write_rd_data: got %h want 00", rd_data);
    end
  endtask

`ifdef ADC_SPI_READ_EN
  task automatic test_read();
    int d, r, s, dc;
    logic [7:0] rd;
    resp = 24'h0000_A7;
    do_frame(1'b1, 12'h123, 8'h55, d, r, s, dc, rd);
    total++; if (d != 197) begin bad++; $display("FAIL read_done_at: got %0d want 197", d); end
    total++;
    if (cap[23:8] !== 16'h8123) begin
      bad++; $display("FAIL read_header: got %h want 8123", cap[23:8]);
    end
    total++;
    if (oe_cap !== 24'hFFFF00) begin
      bad++; $display("FAIL read_oe: got %h want ffff00", oe_cap);
    end
    total++;
    if (rd !== 8'hA7) begin
      bad++; $display("FAIL read_data: got %h want a7", rd);
    end
    resp = 24'h0000_5A;
    do_frame(1'b0, 12'h010, 8'h99, d, r, s, dc, rd);
    total++;
    if (rd_data !== 8'hA7) begin
      bad++; $display("FAIL write_keeps_rd_data: got %h want a7", rd_data);
    end
  endtask
`else
  task automatic test_read_reject();
    bit acc = 1'b0;
    int errs = 0, err1 = 0, sen_low = 0, busy_n = 0, not_ready = 0, dn = 0, oe_n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h123; cmd_wdata = 8'h00;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_valid = 1'b0; cmd_rw = 1'b0;
        if (err) err1 = 1;
      end
      if (err) errs++;
      if (!sen) sen_low++;
      if (busy) busy_n++;
      if (!cmd_ready) not_ready++;
      if (done) dn++;
      if (sdio_oe) oe_n++;
    end
    total++; if (!acc) begin bad++; $display("FAIL reject_accept: got 0 want 1"); end
    total++; if (err1 != 1) begin bad++; $display("FAIL reject_err_timing: got %0d want 1", err1); end
    total++; if (errs != 1) begin bad++; $display("FAIL reject_err_width: got %0d want 1", errs); end
    total++; if (sen_low != 0) begin bad++; $display("FAIL reject_sen: got %0d low cycles want 0", sen_low); end
    total++; if (busy_n != 0) begin bad++; $display("FAIL reject_busy: got %0d busy cycles want 0", busy_n); end
    total++;
    if (not_ready + dn + oe_n != 0) begin
      bad++; $display("FAIL reject_quiet: got ready_low=%0d done=%0d oe=%0d want 0", not_ready, dn, oe_n);
    end
    total++;
    if (rd_data !== 8'h00) begin
      bad++; $display("FAIL reject_rd_data: got %h want 00", rd_data);
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit acc = 1'b0;
    int d1 = -1, d2 = -1, a2 = -1, hi = 0;
    logic [23:0] cap1 = '0, cap2 = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h321; cmd_wdata = 8'hC4;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    for (int n = 1; n <= 600 && acc; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_addr = 12'h7E1; cmd_wdata = 8'h18;
      end
      if (a2 >= 0 && n == a2 + 1) cmd_valid = 1'b0;
      if (done) begin
        if (d1 < 0) begin
          d1 = n; cap1 = cap;
        end else if (d2 < 0) begin
          d2 = n; cap2 = cap;
        end
      end
      if (d1 >= 0 && a2 < 0 && sen) hi++;
      if (d1 >= 0 && a2 < 0 && cmd_ready && cmd_valid) a2 = n;
      if (d2 >= 0) break;
    end
    cmd_valid = 1'b0;
    total++; if (d1 != 197) begin bad++; $display("FAIL b2b_done1: got %0d want 197", d1); end
    total++; if (a2 - d1 != 4) begin bad++; $display("FAIL b2b_accept_gap: got %0d want 4", a2 - d1); end
    total++; if (hi != 5) begin bad++; $display("FAIL b2b_sen_high: got %0d want 5", hi); end
    total++; if (d2 - a2 != 197) begin bad++; $display("FAIL b2b_done2: got %0d want 197", d2 - a2); end
    total++;
    if (cap1 !== 24'h0321C4) begin
      bad++; $display("FAIL b2b_capture1: got %h want 0321c4", cap1);
    end
    total++;
    if (cap2 !== 24'h07E118) begin
      bad++; $display("FAIL b2b_capture2: got %h want 07e118", cap2);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc = 1'b0;
    int dn = 0, sen_low = 0, d, r, s, dc;
    logic [7:0] rd;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h5A5; cmd_wdata = 8'h66;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rises >= 14) break;
      @(negedge clk);
    end
    total++;
    if (rises != 14 || sclk !== 1'b1) begin
      bad++; $display("FAIL mid_reach_bit10: got rises=%0d sclk=%b want 14/1", rises, sclk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sen, sclk, sdio_oe, busy} !== 4'b1000) begin
      bad++; $display("FAIL mid_async_reset: got %b want 1000", {sen, sclk, sdio_oe, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      if (done) dn++;
      if (!sen) sen_low++;
    end
    total++;
    if (dn + sen_low != 0) begin
      bad++; $display("FAIL mid_abandon: got done=%0d sen_low=%0d want 0", dn, sen_low);
    end
    do_frame(1'b0, 12'hABC, 8'h5D, d, r, s, dc, rd);
    total++; if (d != 197) begin bad++; $display("FAIL mid_next_done: got %0d want 197", d); end
    total++;
    if (cap !== 24'h0ABC5D) begin
      bad++; $display("FAIL mid_next_capture: got %h want 0abc5d", cap);
    end
  endtask

  task automatic test_fast_timing();
    int d = -1, r = -1, hi = 0, low = 0;
    bit acc = 1'b0;
    @(negedge clk);
    f_valid = 1'b1; f_addr = 12'hFFF; f_wdata = 8'hFF;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (f_ready) acc = 1'b1;
      else @(negedge clk);
    end
    for (int n = 1; n <= 100 && acc; n++) begin
      @(negedge clk);
      if (n == 1) begin
        f_valid = 1'b0; f_addr = '0; f_wdata = '0;
      end
      if (f_sclk) hi++;
      if (!f_sen) low++;
      if (f_done && d < 0) d = n;
      if (f_ready) begin
        r = n;
        break;
      end
    end
    total++; if (d != 51) begin bad++; $display("FAIL fast_done_at: got %0d want 51", d); end
    total++; if (r != 52) begin bad++; $display("FAIL fast_ready_at: got %0d want 52", r); end
    total++; if (f_rises != 24) begin bad++; $display("FAIL fast_rises: got %0d want 24", f_rises); end
    total++; if (hi != 24) begin bad++; $display("FAIL fast_sclk_high: got %0d want 24", hi); end
    total++; if (low != 50) begin bad++; $display("FAIL fast_sen_low: got %0d want 50", low); end
    total++;
    if (f_cap !== 24'h0FFFFF) begin
      bad++; $display("FAIL fast_capture: got %h want 0fffff", f_cap);
    end
  endtask

  initial begin
    test_reset();
    test_write();
`ifdef ADC_SPI_READ_EN
    test_read();
`else
    test_read_reject();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    test_fast_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
